mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control sequencer that replaces the single-cycle decoder so the CPU datapath (PC, instruction register, register file, ALU, data memory, next-PC logic) runs one instruction over 2–5 states. It decodes opcode/funct from the instruction-register output and drives every write strobe and mux select in the datapath. It stalls on a memory-ready handshake and retires instructions by pulsing `PCWr`. It also counts retired instructions and traps on unsupported encodings.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `opcode` in 6: inst[31:26] from the instruction register.
- `funct` in 6: inst[5:0] from the instruction register.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access complete this cycle. Applies to instruction memory in FETCH and to data memory in MEM.
- `PCWr` out 1: PC load strobe, which is also the retire pulse.
- `IRWr` out 1: instruction register load.
- `RegWrite` out 1: register file write.
- `MemWrite` out 1: data memory write.
- `RegDst` out 2: 0 = rt, 1 = rd, 2 = r31.
- `RegSrc` out 2: 0 = ALU, 1 = MEM, 2 = PC+4.
- `ALUSrcA` out 1: 1 = shamt.
- `ALUSrcB` out 1: 1 = imm32.
- `ALUOp` out 4: ALU operation.
- `NPCOp` out 2: 0 = PLUS4, 1 = BRANCH, 2 = JUMP, 3 = JR.
- `trap` out 1: sticky illegal-instruction flag.
- `state` out 3: current state, for debug.
- `instret` out `INSTRET_W`: retired-instruction count.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- FETCH:
  - `IRWr` = `mem_ready`.
  - Stay in FETCH while `mem_ready` = 0; go to DECODE when it is 1.
- DECODE:
  - j: `PCWr` = 1, `NPCOp` = JUMP, next state FETCH.
  - jal: additionally `RegWrite` = 1, `RegDst` = 2, `RegSrc` = 2.
  - Illegal encoding: next state TRAP.
  - All other instructions: next state EXEC.
- EXEC:
  - ALU-class instructions: next state WB.
  - lw/sw: next state MEM.
  - beq/bne: `PCWr` = 1, `NPCOp` = BRANCH when (`Zero` XOR bne), else PLUS4; next state FETCH.
  - jr: `PCWr` = 1, `NPCOp` = JR; next state FETCH.
- MEM: stay in MEM while `mem_ready` = 0.
  - sw: `MemWrite` = `mem_ready`; on `mem_ready` also `PCWr` = 1 and next state FETCH.
  - lw: on `mem_ready`, next state WB.
- WB: `RegWrite` = 1, `PCWr` = 1, `NPCOp` = PLUS4.
  - R-type: `RegDst` = 1, `RegSrc` = 0.
  - addi: `RegDst` = 0, `RegSrc` = 0.
  - lw: `RegDst` = 0, `RegSrc` = 1.
- TRAP: `trap` = 1; all strobes are 0; the state is left only by reset.
- Supported instructions:
  - R-type (opcode 0), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - Other opcodes: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
  - Anything else is illegal.
- ALU controls in EXEC, MEM and WB are held constant:
  - `ALUOp` follows the decoded operation.
  - `ALUSrcA` = 1 only for sll/srl.
  - `ALUSrcB` = 1 for addi, lw and sw.
  - beq/bne use SUB.
  - In FETCH and DECODE: `ALUOp` = ADD, both `ALUSrc*` = 0.
- Stable-data rule: the PC changes only on the instruction's final cycle, so PC and PC+4 stay valid throughout the instruction.
- `instret` increments by 1 on every cycle with `PCWr` = 1 and wraps modulo 2^`INSTRET_W`.

## Timing
- Cycle counts with zero-wait memory (`mem_ready` = 1):

  | Instruction | Cycles |
  |---|---|
  | j, jal | 2 |
  | beq, bne, jr | 3 |
  | R-type ALU, addi, sw | 4 |
  | lw | 5 |

- Each cycle with `mem_ready` = 0 in FETCH or MEM adds one cycle.
- All strobe and select outputs are Moore/Mealy combinational from the state register, the inputs and the instruction fields; there are no registered outputs except `state`, `trap` and `instret`.
- Reset:
  - While `rst` = 1, `state` = FETCH and `instret` = 0.
  - `trap` = 0.
  - `PCWr`, `IRWr`, `RegWrite` and `MemWrite` are forced to 0.
  - Selects are 0.
- Reset asserted mid-instruction aborts that instruction; no partial write occurs after `rst` rises.
- Simultaneous events:
  - `PCWr` and `RegWrite` in the same cycle (jal, WB) are both legal; the datapath samples both on the same edge.
  - `mem_ready` asserted in the first FETCH cycle after reset release is honoured.

## Structure
- Shared constants in a package/header (alongside the existing control encodings):
  - State codes.
  - `ALUOp` codes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, SLL 5, SRL 6.
  - `NPCOp`, `RegDst` and `RegSrc` codes.
  - Opcode and funct values.
- One sub-module, `mc_decode`: purely combinational instruction classification (class and `ALUOp`) from opcode/funct. The FSM, the strobe generation and `instret` live in `mc_ctrl_fsm`.

## Test plan
- add (op 0, funct 0x20), `mem_ready` = 1: states 0→1→2→4→0.
  - `RegWrite` = 1 and `PCWr` = 1 only in WB, `RegDst` = 1.
  - `instret` goes 0→1.
- lw (0x23) with `mem_ready` low for 2 cycles in MEM: 7 cycles total.
  - `RegSrc` = 1 in WB.
  - `MemWrite` = 0 throughout.
- beq with `Zero` = 1: `NPCOp` = 1 in EXEC. bne with `Zero` = 1: `NPCOp` = 0. Both retire in 3 cycles.
- jal: retires in 2 cycles, with `RegWrite` = 1, `RegDst` = 2, `RegSrc` = 2, `NPCOp` = 2 in the same DECODE cycle.
- Opcode 0x3F: TRAP after DECODE.
  - `trap` = 1 and stays high for 10 cycles with no strobes.
  - Reset clears it, then `state` = 0.
- `rst` pulsed in MEM of sw with `mem_ready` = 0: no `MemWrite`; after release `state` = 0 and `instret` = 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, instruction
// classes, ALU/next-PC/write-back select codes and opcode/funct values.
package mc_ctrl_fsm_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned ALUOP_W  = 4;
   localparam int unsigned CLASS_W  = 4;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   // Instruction classes produced by mc_decode
   localparam logic [CLASS_W-1:0] C_ILLEGAL = 4'd0;
   localparam logic [CLASS_W-1:0] C_RALU    = 4'd1;
   localparam logic [CLASS_W-1:0] C_ADDI    = 4'd2;
   localparam logic [CLASS_W-1:0] C_LW      = 4'd3;
   localparam logic [CLASS_W-1:0] C_SW      = 4'd4;
   localparam logic [CLASS_W-1:0] C_BEQ     = 4'd5;
   localparam logic [CLASS_W-1:0] C_BNE     = 4'd6;
   localparam logic [CLASS_W-1:0] C_J       = 4'd7;
   localparam logic [CLASS_W-1:0] C_JAL     = 4'd8;
   localparam logic [CLASS_W-1:0] C_JR      = 4'd9;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd5;
   localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd6;

   localparam logic [SEL_W-1:0] NPC_PLUS4  = 2'd0;
   localparam logic [SEL_W-1:0] NPC_BRANCH = 2'd1;
   localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
   localparam logic [SEL_W-1:0] NPC_JR     = 2'd3;

   localparam logic [SEL_W-1:0] REGDST_RT  = 2'd0;
   localparam logic [SEL_W-1:0] REGDST_RD  = 2'd1;
   localparam logic [SEL_W-1:0] REGDST_R31 = 2'd2;

   localparam logic [SEL_W-1:0] REGSRC_ALU = 2'd0;
   localparam logic [SEL_W-1:0] REGSRC_MEM = 2'd1;
   localparam logic [SEL_W-1:0] REGSRC_PC4 = 2'd2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [OP_W-1:0] F_SLL = 6'h00;
   localparam logic [OP_W-1:0] F_SRL = 6'h02;
   localparam logic [OP_W-1:0] F_JR  = 6'h08;
   localparam logic [OP_W-1:0] F_ADD = 6'h20;
   localparam logic [OP_W-1:0] F_SUB = 6'h22;
   localparam logic [OP_W-1:0] F_AND = 6'h24;
   localparam logic [OP_W-1:0] F_OR  = 6'h25;
   localparam logic [OP_W-1:0] F_SLT = 6'h2A;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class and the ALU operation used while that instruction executes.
module mc_decode
   import mc_ctrl_fsm_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] cls,
   output logic [3:0] aluop
);

   always_comb begin
      cls   = C_ILLEGAL;
      aluop = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD: cls = C_RALU;
               F_SUB: begin cls = C_RALU; aluop = ALU_SUB; end
               F_AND: begin cls = C_RALU; aluop = ALU_AND; end
               F_OR:  begin cls = C_RALU; aluop = ALU_OR;  end
               F_SLT: begin cls = C_RALU; aluop = ALU_SLT; end
               F_SLL: begin cls = C_RALU; aluop = ALU_SLL; end
               F_SRL: begin cls = C_RALU; aluop = ALU_SRL; end
               F_JR:  cls = C_JR;
               default: cls = C_ILLEGAL;
            endcase
         end
         OP_ADDI: cls = C_ADDI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ:  begin cls = C_BEQ; aluop = ALU_SUB; end
         OP_BNE:  begin cls = C_BNE; aluop = ALU_SUB; end
         OP_J:    cls = C_J;
         OP_JAL:  cls = C_JAL;
         default: cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: walks each instruction through FETCH..WB,
// drives datapath strobes/selects combinationally and counts retirements.
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 PCWr,
   output logic                 IRWr,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic [1:0]           RegDst,
   output logic [1:0]           RegSrc,
   output logic                 ALUSrcA,
   output logic                 ALUSrcB,
   output logic [3:0]           ALUOp,
   output logic [1:0]           NPCOp,
   output logic                 trap,
   output logic [2:0]           state,
   output logic [INSTRET_W-1:0] instret
);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cls;
   logic [3:0] dec_aluop;
   logic       alu_hold;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .cls    (cls),
      .aluop  (dec_aluop)
   );

   assign state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         trap    <= 1'b0;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP) trap <= 1'b1;
         if (PCWr) instret <= instret + INSTRET_W'(1);
      end
   end

   // Next state plus strobes; PC only moves on an instruction's last cycle
   always_comb begin
      state_d  = state_q;
      alu_hold = 1'b0;
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      RegDst   = REGDST_RT;
      RegSrc   = REGSRC_ALU;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 1'b0;
      ALUOp    = ALU_ADD;
      NPCOp    = NPC_PLUS4;
      case (state_q)
         S_FETCH: begin
            IRWr = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               C_J: begin
                  PCWr    = 1'b1;
                  NPCOp   = NPC_JUMP;
                  state_d = S_FETCH;
               end
               C_JAL: begin
                  PCWr     = 1'b1;
                  NPCOp    = NPC_JUMP;
                  RegWrite = 1'b1;
                  RegDst   = REGDST_R31;
                  RegSrc   = REGSRC_PC4;
                  state_d  = S_FETCH;
               end
               C_ILLEGAL: state_d = S_TRAP;
               default:   state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            alu_hold = 1'b1;
            case (cls)
               C_LW, C_SW: state_d = S_MEM;
               C_BEQ, C_BNE: begin
                  PCWr = 1'b1;
                  if (Zero ^ (cls == C_BNE)) NPCOp = NPC_BRANCH;
                  state_d = S_FETCH;
               end
               C_JR: begin
                  PCWr    = 1'b1;
                  NPCOp   = NPC_JR;
                  state_d = S_FETCH;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            alu_hold = 1'b1;
            if (mem_ready) begin
               if (cls == C_SW) begin
                  MemWrite = 1'b1;
                  PCWr     = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            alu_hold = 1'b1;
            RegWrite = 1'b1;
            PCWr     = 1'b1;
            state_d  = S_FETCH;
            if (cls == C_RALU) RegDst = REGDST_RD;
            if (cls == C_LW)   RegSrc = REGSRC_MEM;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      if (alu_hold) begin
         ALUOp   = dec_aluop;
         ALUSrcA = (dec_aluop == ALU_SLL) || (dec_aluop == ALU_SRL);
         ALUSrcB = (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);
      end

      // Reset kills every strobe and select so no partial write escapes
      if (rst) begin
         PCWr     = 1'b0;
         IRWr     = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         RegDst   = REGDST_RT;
         RegSrc   = REGSRC_ALU;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 1'b0;
         ALUOp    = ALU_ADD;
         NPCOp    = NPC_PLUS4;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle
// against hand-derived state sequences and strobe values.
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        Zero;
   logic        mem_ready;
   logic        PCWr, IRWr, RegWrite, MemWrite, ALUSrcA, ALUSrcB, trap;
   logic [1:0]  RegDst, RegSrc, NPCOp;
   logic [3:0]  ALUOp;
   logic [2:0]  state;
   logic [31:0] instret;

   int total = 0;
   int bad   = 0;

   mc_ctrl_fsm #(.INSTRET_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
      .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .RegDst(RegDst), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .NPCOp(NPCOp), .trap(trap),
      .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "timeout");
   end

   // Drive one cycle's inputs at the falling edge and let outputs settle
   task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
      @(negedge clk);
      opcode = op; funct = fn; Zero = z; mem_ready = rdy;
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; Zero = 1'b0;
      #1;
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
      total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b want=0", trap); end
      total++; if ({PCWr, IRWr, RegWrite, MemWrite} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes got=%b want=0000", {PCWr, IRWr, RegWrite, MemWrite}); end
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0;
      cyc(6'h00, 6'h20, 1'b0, 1'b0);
      total++; if (state !== 3'd0 || IRWr !== 1'b0) begin
         bad++; $display("FAIL fetch_stall state=%0d irwr=%b want state=0 irwr=0", state, IRWr); end
   endtask

   task automatic test_add;
      int st[4] = '{0, 1, 2, 4};
      for (int i = 0; i < 4; i++) begin
         cyc(6'h00, 6'h20, 1'b0, 1'b1);
         total++; if (state !== 3'(st[i])) begin bad++; $display("FAIL add_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         total++; if (PCWr !== (i == 3) || RegWrite !== (i == 3)) begin
            bad++; $display("FAIL add_strobes[%0d] pcwr=%b regwrite=%b want=%b", i, PCWr, RegWrite, i == 3); end
         if (i == 0) begin
            total++; if (IRWr !== 1'b1) begin bad++; $display("FAIL add_irwr got=%b want=1", IRWr); end
         end
         if (i == 3) begin
            total++; if (RegDst !== 2'd1 || RegSrc !== 2'd0 || NPCOp !== 2'd0) begin
               bad++; $display("FAIL add_wb_sel regdst=%0d regsrc=%0d npcop=%0d want 1 0 0", RegDst, RegSrc, NPCOp); end
            total++; if (instret !== 32'd0) begin bad++; $display("FAIL add_instret_pre got=%0d want=0", instret); end
         end
      end
      @(posedge clk); #1;
      total++; if (state !== 3'd0 || instret !== 32'd1) begin
         bad++; $display("FAIL add_retire state=%0d instret=%0d want 0 1", state, instret); end
   endtask

   task automatic test_lw;
      int st[7]  = '{0, 1, 2, 3, 3, 3, 4};
      int rdy[7] = '{1, 1, 1, 0, 0, 1, 1};
      for (int i = 0; i < 7; i++) begin
         cyc(6'h23, 6'h00, 1'b0, 1'(rdy[i]));
         total++; if (state !== 3'(st[i])) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         total++; if (MemWrite !== 1'b0 || PCWr !== (i == 6)) begin
            bad++; $display("FAIL lw_strobes[%0d] memwrite=%b pcwr=%b", i, MemWrite, PCWr); end
         if (i >= 2) begin
            total++; if (ALUSrcB !== 1'b1 || ALUOp !== 4'd0) begin
               bad++; $display("FAIL lw_alu[%0d] srcb=%b aluop=%0d want 1 0", i, ALUSrcB, ALUOp); end
         end
         if (i == 6) begin
            total++; if (RegSrc !== 2'd1 || RegDst !== 2'd0 || RegWrite !== 1'b1) begin
               bad++; $display("FAIL lw_wb regsrc=%0d regdst=%0d regwrite=%b want 1 0 1", RegSrc, RegDst, RegWrite); end
         end
      end
      @(posedge clk); #1;
      total++; if (state !== 3'd0 || instret !== 32'd2) begin
         bad++; $display("FAIL lw_retire state=%0d instret=%0d want 0 2", state, instret); end
   endtask

   task automatic test_branch;
      logic [5:0] ops[2] = '{6'h04, 6'h05};
      logic [1:0] npc[2] = '{2'd1, 2'd0};
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 3; i++) begin
            cyc(ops[b], 6'h00, 1'b1, 1'b1);
            total++; if (state !== 3'(i)) begin bad++; $display("FAIL br%0d_state[%0d] got=%0d want=%0d", b, i, state, i); end
            if (i == 2) begin
               total++; if (PCWr !== 1'b1 || NPCOp !== npc[b] || ALUOp !== 4'd1) begin
                  bad++; $display("FAIL br%0d_exec pcwr=%b npcop=%0d aluop=%0d want 1 %0d 1", b, PCWr, NPCOp, ALUOp, npc[b]); end
            end
         end
         @(posedge clk); #1;
         total++; if (state !== 3'd0 || instret !== 32'(3 + b)) begin
            bad++; $display("FAIL br%0d_retire state=%0d instret=%0d want 0 %0d", b, state, instret, 3 + b); end
      end
   endtask

   task automatic test_jal;
      cyc(6'h03, 6'h00, 1'b0, 1'b1);
      cyc(6'h03, 6'h00, 1'b0, 1'b1);
      total++; if (state !== 3'd1 || PCWr !== 1'b1 || RegWrite !== 1'b1) begin
         bad++; $display("FAIL jal_decode state=%0d pcwr=%b regwrite=%b want 1 1 1", state, PCWr, RegWrite); end
      total++; if (RegDst !== 2'd2 || RegSrc !== 2'd2 || NPCOp !== 2'd2) begin
         bad++; $display("FAIL jal_sel regdst=%0d regsrc=%0d npcop=%0d want 2 2 2", RegDst, RegSrc, NPCOp); end
      @(posedge clk); #1;
      total++; if (state !== 3'd0 || instret !== 32'd5) begin
         bad++; $display("FAIL jal_retire state=%0d instret=%0d want 0 5", state, instret); end
   endtask

   task automatic test_jr_sll;
      for (int i = 0; i < 3; i++) cyc(6'h00, 6'h08, 1'b0, 1'b1);
      total++; if (state !== 3'd2 || PCWr !== 1'b1 || NPCOp !== 2'd3 || RegWrite !== 1'b0) begin
         bad++; $display("FAIL jr_exec state=%0d pcwr=%b npcop=%0d regwrite=%b want 2 1 3 0", state, PCWr, NPCOp, RegWrite); end
      for (int i = 0; i < 3; i++) cyc(6'h00, 6'h00, 1'b0, 1'b1);
      total++; if (state !== 3'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 1'b0 || ALUOp !== 4'd5 || PCWr !== 1'b0) begin
         bad++; $display("FAIL sll_exec state=%0d srca=%b srcb=%b aluop=%0d pcwr=%b want 2 1 0 5 0", state, ALUSrcA, ALUSrcB, ALUOp, PCWr); end
      cyc(6'h00, 6'h00, 1'b0, 1'b1);
      total++; if (state !== 3'd4 || RegDst !== 2'd1 || ALUOp !== 4'd5 || PCWr !== 1'b1) begin
         bad++; $display("FAIL sll_wb state=%0d regdst=%0d aluop=%0d pcwr=%b want 4 1 5 1", state, RegDst, ALUOp, PCWr); end
      @(posedge clk); #1;
      total++; if (instret !== 32'd7) begin bad++; $display("FAIL jr_sll_retire instret=%0d want 7", instret); end
   endtask

   task automatic test_trap;
      cyc(6'h3F, 6'h00, 1'b0, 1'b1);
      cyc(6'h3F, 6'h00, 1'b0, 1'b1);
      total++; if (state !== 3'd1 || PCWr !== 1'b0 || trap !== 1'b0) begin
         bad++; $display("FAIL trap_decode state=%0d pcwr=%b trap=%b want 1 0 0", state, PCWr, trap); end
      for (int i = 0; i < 10; i++) begin
         cyc(6'h3F, 6'h00, 1'b1, 1'b1);
         total++; if (state !== 3'd5 || trap !== 1'b1 ||
                      {PCWr, IRWr, RegWrite, MemWrite} !== 4'b0000) begin
            bad++; $display("FAIL trap_hold[%0d] state=%0d trap=%b strobes=%b want 5 1 0000",
                            i, state, trap, {PCWr, IRWr, RegWrite, MemWrite}); end
      end
      total++; if (instret !== 32'd7) begin bad++; $display("FAIL trap_instret got=%0d want 7", instret); end
      @(negedge clk); rst = 1'b1; #1;
      total++; if (trap !== 1'b0 || state !== 3'd0 || instret !== 32'd0) begin
         bad++; $display("FAIL trap_clear trap=%b state=%0d instret=%0d want 0 0 0", trap, state, instret); end
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid_sw;
      int st[4]  = '{0, 1, 2, 3};
      int rdy[4] = '{1, 1, 1, 0};
      for (int i = 0; i < 4; i++) begin
         cyc(6'h2B, 6'h00, 1'b0, 1'(rdy[i]));
         total++; if (state !== 3'(st[i]) || MemWrite !== 1'b0) begin
            bad++; $display("FAIL sw_state[%0d] state=%0d memwrite=%b want %0d 0", i, state, MemWrite, st[i]); end
      end
      total++; if (ALUSrcB !== 1'b1) begin bad++; $display("FAIL sw_srcb got=%b want 1", ALUSrcB); end
      @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
      total++; if (MemWrite !== 1'b0 || PCWr !== 1'b0 || state !== 3'd0) begin
         bad++; $display("FAIL sw_abort memwrite=%b pcwr=%b state=%0d want 0 0 0", MemWrite, PCWr, state); end
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
      total++; if (state !== 3'd0 || instret !== 32'd0) begin
         bad++; $display("FAIL sw_release state=%0d instret=%0d want 0 0", state, instret); end
      // A single-cycle sw after reset: MemWrite and retire coincide in MEM
      for (int i = 0; i < 4; i++) cyc(6'h2B, 6'h00, 1'b0, 1'b1);
      total++; if (state !== 3'd3 || MemWrite !== 1'b1 || PCWr !== 1'b1) begin
         bad++; $display("FAIL sw_mem state=%0d memwrite=%b pcwr=%b want 3 1 1", state, MemWrite, PCWr); end
      @(posedge clk); #1;
      total++; if (state !== 3'd0 || instret !== 32'd1) begin
         bad++; $display("FAIL sw_retire state=%0d instret=%0d want 0 1", state, instret); end
   endtask

   initial begin
      rst = 1'b1; opcode = 6'h00; funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
      test_reset();
      test_add();
      test_lw();
      test_branch();
      test_jal();
      test_jr_sll();
      test_trap();
      test_reset_mid_sw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
